// File: rtl/demux_stream_n_pkg.sv
// -----------------------------------------------------------------------------
// demux_stream_n_pkg
// Shared types and constants for the demux_stream_n block.
//   - MAX_SEL_W : largest supported key width (32 channels)
//   - slot_op_e : per-edge action taken by a holding slot
// Optional feature macro used elsewhere in this slice: DEMUX_STREAM_BCAST_EN.
// -----------------------------------------------------------------------------
package demux_stream_n_pkg;

  localparam int MAX_SEL_W = 5;

  // What a holding slot does on the coming clock edge.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_DRAIN = 2'd2
  } slot_op_e;

endpackage

// File: rtl/demux_stream_n_if.sv
// -----------------------------------------------------------------------------
// demux_stream_n_if
// Handshake bundle between one producer, the demux and N consumers.
//   in_valid/in_ready/in_data/in_key : producer side
//   in_bcast                         : broadcast request (DEMUX_STREAM_BCAST_EN)
//   out_valid/out_ready/out_data     : N consumer lanes, lane k at
//                                      out_data[k*DATA_W +: DATA_W]
// Modports: master = environment (producer + consumers), slave = demux.
// -----------------------------------------------------------------------------
interface demux_stream_n_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  localparam int N = 32'sd1 << SEL_W;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [SEL_W-1:0]    in_key;
  logic [N-1:0]        out_valid;
  logic [N-1:0]        out_ready;
  logic [N*DATA_W-1:0] out_data;
`ifdef DEMUX_STREAM_BCAST_EN
  logic                in_bcast;

  modport master (
    output in_valid, in_data, in_key, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_key, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
`else
  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry holding register for a single demux output lane.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data and mark the slot full (wins over drain)
//   drain      : consumer takes the word; slot empties unless reloaded
//   load_data  : word to capture
//   valid      : slot holds a word
//   data       : held word (keeps its last value once drained)
// -----------------------------------------------------------------------------
module demux_slot
  import demux_stream_n_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  slot_op_e          op_s;
  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  // Choose the slot action; a load in the same cycle as a drain keeps it full.
  always_comb begin
    op_s = OP_HOLD;
    if (load) begin
      op_s = OP_LOAD;
    end else if (drain) begin
      op_s = OP_DRAIN;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else begin
      case (op_s)
        OP_LOAD: begin
          valid_r <= 1'b1;
          data_r  <= load_data;
        end
        OP_DRAIN: begin
          valid_r <= 1'b0;
        end
        default: begin
          valid_r <= valid_r;
          data_r  <= data_r;
        end
      endcase
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/demux_stream_n.sv
// -----------------------------------------------------------------------------
// demux_stream_n
// Registered, handshaked 1-to-N demultiplexer. A word accepted with key k is
// held in slot k until consumer k takes it; a full, stalled slot only blocks
// inputs keyed to that slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 0 blocks new acceptances; held words keep draining
//   bus        : demux_stream_n_if.slave (producer + N consumer lanes)
// Optional feature: DEMUX_STREAM_BCAST_EN adds in_bcast; an accepted broadcast
// word is loaded into every slot and needs all slots free-or-draining.
// The demux_defs block below is the shared, include-guarded macro header.
// -----------------------------------------------------------------------------
`ifndef DEMUX_DEFS_V
`define DEMUX_DEFS_V
// Channel count from key width.
`define DEMUX_CHANS(sel_w) (32'sd1 << (sel_w))
// Part-select of lane k within a packed N*w vector.
`define DEMUX_LANE(k, w) ((k) * (w)) +: (w)
`endif

module demux_stream_n
  import demux_stream_n_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  demux_stream_n_if.slave      bus
);

  localparam int N = `DEMUX_CHANS(SEL_W);

  logic [N-1:0]        free_s;
  logic [N-1:0]        sel_s;
  logic [N-1:0]        tgt_s;
  logic [N-1:0]        load_s;
  logic [N-1:0]        drain_s;
  logic [N-1:0]        valid_s;
  logic [N*DATA_W-1:0] data_s;
  logic                in_ready_s;
  logic                accept_s;

  // A slot can take a new word if it is empty or being emptied this cycle.
  assign free_s  = ~valid_s | bus.out_ready;
  assign drain_s = valid_s & bus.out_ready;

  // One-hot key decoder.
  always_comb begin
    sel_s = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      sel_s[k] = (bus.in_key == SEL_W'(k));
    end
  end

  // Ready mux and target-slot selection; never looks at in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    tgt_s      = {N{1'b0}};
`ifdef DEMUX_STREAM_BCAST_EN
    if (bus.in_bcast) begin
      in_ready_s = enable & (&free_s);
      tgt_s      = {N{1'b1}};
    end else begin
      in_ready_s = enable & free_s[bus.in_key];
      tgt_s      = sel_s;
    end
`else
    in_ready_s = enable & free_s[bus.in_key];
    tgt_s      = sel_s;
`endif
  end

  assign accept_s = bus.in_valid & in_ready_s;
  assign load_s   = tgt_s & {N{accept_s}};

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s[g]),
      .drain     (drain_s[g]),
      .load_data (bus.in_data),
      .valid     (valid_s[g]),
      .data      (data_s[`DEMUX_LANE(g, DATA_W)])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = data_s;

endmodule

// File: tb/tb_demux_stream_n.sv
// -----------------------------------------------------------------------------
// tb_demux_stream_n
// Self-checking bench for demux_stream_n. A slot-level reference model (arrays
// of valid flags and held words) is advanced once per clock from the driven
// inputs; DUT outputs are compared against it and against fixed constants.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_demux_stream_n;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;
  localparam int N      = 1 << SEL_W;

  logic clk;
  logic rst_n;
  logic enable;
  logic bcast;

  int n_checks;
  int n_fail;

  logic [N-1:0]      exp_valid;
  logic [DATA_W-1:0] exp_data [N];

  demux_stream_n_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

`ifdef DEMUX_STREAM_BCAST_EN
  assign bus.in_bcast = bcast;
`endif

  demux_stream_n #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: would the block take a word right now?
  function automatic logic model_ready();
    logic all_free;
    int   key;
    all_free = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (exp_valid[k] && !bus.out_ready[k]) all_free = 1'b0;
    end
    key = int'(bus.in_key);
    if (!enable) return 1'b0;
    if (bcast) return all_free;
    return !exp_valid[key] || bus.out_ready[key];
  endfunction

  function automatic logic [DATA_W-1:0] lane(input int k);
    return bus.out_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic model_clear();
    exp_valid = '0;
    for (int k = 0; k < N; k++) exp_data[k] = '0;
  endtask

  // Advance one clock and update the reference from the pre-edge inputs.
  task automatic tick();
    logic              acc;
    int                key;
    logic [N-1:0]      nv;
    logic [DATA_W-1:0] nd [N];
    acc = bus.in_valid && model_ready();
    key = int'(bus.in_key);
    for (int k = 0; k < N; k++) begin
      nv[k] = exp_valid[k];
      nd[k] = exp_data[k];
      if (acc && (bcast || k == key)) begin
        nv[k] = 1'b1;
        nd[k] = bus.in_data;
      end else if (exp_valid[k] && bus.out_ready[k]) begin
        nv[k] = 1'b0;
      end
    end
    @(posedge clk);
    exp_valid = nv;
    for (int k = 0; k < N; k++) exp_data[k] = nd[k];
    #1;
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] key, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_key   = key;
    bus.in_data  = d;
    #1;
  endtask

  task automatic go_idle();
    drive(1'b0, '0, '0);
    bus.out_ready = '1;
    enable = 1'b1;
    bcast  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    bcast  = 1'b0;
    bus.out_ready = '0;
    drive(1'b0, '0, '0);
    #1;
    n_checks++;
    if (bus.out_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    go_idle();
    bus.out_ready = '0;
    drive(1'b1, 2'd1, 8'h31);
    tick();
    drive(1'b1, 2'd3, 8'h33);
    tick();
    drive(1'b0, '0, '0);
    n_checks++;
    if (bus.out_valid !== 4'b1010) begin n_fail++; $display("FAIL mid_prefill: got %b expected 1010", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0000", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL mid_reset_data: got %h expected 0", bus.out_data); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_unicast();
    go_idle();
    for (int k = 0; k < N; k++) begin
      drive(1'b1, SEL_W'(k), 8'hA0 + 8'(k));
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL uni_ready%0d: got %b expected 1", k, bus.in_ready); end
      tick();
      n_checks++;
      if (bus.out_valid !== (N'(1) << k)) begin n_fail++; $display("FAIL uni_valid%0d: got %b expected %b", k, bus.out_valid, N'(1) << k); end
      n_checks++;
      if (lane(k) !== 8'hA0 + 8'(k)) begin n_fail++; $display("FAIL uni_data%0d: got %h expected %h", k, lane(k), 8'hA0 + 8'(k)); end
    end
    drive(1'b0, '0, '0);
    tick();
    n_checks++;
    if (bus.out_valid !== '0) begin n_fail++; $display("FAIL uni_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    go_idle();
    bus.out_ready = 4'b1011;
    drive(1'b1, 2'd2, 8'h55);
    tick();
    drive(1'b1, 2'd2, 8'h66);
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: got %b expected 0", c, bus.in_ready); end
      n_checks++;
      if (bus.out_valid[2] !== 1'b1 || lane(2) !== 8'h55) begin n_fail++; $display("FAIL bp_hold%0d: got %b/%h expected 1/55", c, bus.out_valid[2], lane(2)); end
      tick();
    end
    bus.out_ready = 4'b1111;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL bp_lane1_early: got %b expected 0", bus.out_valid[1]); end
    tick();
    n_checks++;
    if (bus.out_valid !== 4'b0100 || lane(2) !== 8'h66) begin n_fail++; $display("FAIL bp_lane2_new: got %b/%h expected 0100/66", bus.out_valid, lane(2)); end
    drive(1'b1, 2'd1, 8'h77);
    tick();
    drive(1'b0, '0, '0);
    n_checks++;
    if (bus.out_valid !== 4'b0010 || lane(1) !== 8'h77) begin n_fail++; $display("FAIL bp_lane1: got %b/%h expected 0010/77", bus.out_valid, lane(1)); end
  endtask

  task automatic test_drain_load();
    go_idle();
    bus.out_ready = 4'b1110;
    drive(1'b1, 2'd0, 8'h11);
    tick();
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'd0, 8'h22);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dl_ready: got %b expected 1", bus.in_ready); end
    tick();
    drive(1'b0, '0, '0);
    n_checks++;
    if (bus.out_valid[0] !== 1'b1 || lane(0) !== 8'h22) begin n_fail++; $display("FAIL dl_lane0: got %b/%h expected 1/22", bus.out_valid[0], lane(0)); end
  endtask

  task automatic test_enable();
    go_idle();
    bus.out_ready = 4'b0000;
    drive(1'b1, 2'd0, 8'hE1);
    tick();
    enable = 1'b0;
    drive(1'b1, 2'd3, 8'h99);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready: got %b expected 0", bus.in_ready); end
    tick();
    n_checks++;
    if (bus.out_valid !== 4'b0001 || lane(0) !== 8'hE1) begin n_fail++; $display("FAIL en_hold: got %b/%h expected 0001/e1", bus.out_valid, lane(0)); end
    bus.out_ready = 4'b0001;
    #1;
    tick();
    n_checks++;
    if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL en_drain: got %b expected 0000", bus.out_valid); end
    enable = 1'b1;
    drive(1'b0, '0, '0);
  endtask

`ifdef DEMUX_STREAM_BCAST_EN
  task automatic test_bcast();
    go_idle();
    bus.out_ready = 4'b0111;
    drive(1'b1, 2'd3, 8'hB3);
    tick();
    bcast = 1'b1;
    drive(1'b1, 2'd1, 8'h3C);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bc_stall: got %b expected 0", bus.in_ready); end
    tick();
    bus.out_ready = 4'b1111;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bc_release: got %b expected 1", bus.in_ready); end
    tick();
    bcast = 1'b0;
    drive(1'b0, '0, '0);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (bus.out_valid[k] !== 1'b1 || lane(k) !== 8'h3C) begin n_fail++; $display("FAIL bc_lane%0d: got %b/%h expected 1/3c", k, bus.out_valid[k], lane(k)); end
    end
  endtask
`endif

  task automatic test_random();
    go_idle();
    for (int c = 0; c < 400; c++) begin
      enable        = ($urandom_range(0, 7) != 0);
      bus.out_ready = N'($urandom);
`ifdef DEMUX_STREAM_BCAST_EN
      bcast = ($urandom_range(0, 9) == 0);
`endif
      drive(1'($urandom), SEL_W'($urandom), DATA_W'($urandom));
      n_checks++;
      if (bus.in_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, bus.in_ready, model_ready()); end
      tick();
      n_checks++;
      if (bus.out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, bus.out_valid, exp_valid); end
      for (int k = 0; k < N; k++) begin
        if (exp_valid[k]) begin
          n_checks++;
          if (lane(k) !== exp_data[k]) begin n_fail++; $display("FAIL rnd_data c%0d lane%0d: got %h expected %h", c, k, lane(k), exp_data[k]); end
        end
      end
    end
    bcast = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    test_reset();
    test_unicast();
    test_backpressure();
    test_drain_load();
    test_enable();
`ifdef DEMUX_STREAM_BCAST_EN
    test_bcast();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
